// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pkg.sv
// Shared sizing helpers for the pipelined N-input NAND: tree depth and per-level term counts.
package gf180mcu_fd_sc_mcu7t5v0__nandn_pkg;

    function automatic int clog3(input int n);
        int r;
        int p;
        r = 0;
        p = 1;
        while (p < n) begin
            p = p * 3;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int levels(input int width);
        int l;
        l = clog3(width);
        return (l < 1) ? 1 : l;
    endfunction

    // Level 0 is the raw input; each following level groups the previous one in threes.
    function automatic int level_terms(input int width, input int k);
        int t;
        t = width;
        for (int i = 0; i < k; i++) begin
            t = (t + 2) / 3;
        end
        return t;
    endfunction

    // Bit position of level k inside a channel's flattened term vector.
    function automatic int term_offset(input int width, input int k);
        int o;
        o = 0;
        for (int i = 0; i < k; i++) begin
            o = o + level_terms(width, i);
        end
        return o;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_level.sv
// One registered radix-3 AND level; a short last group is padded with ones.
// Latency 1 cycle; EN=0 holds the register.
module gf180mcu_fd_sc_mcu7t5v0__nandn_level #(
    parameter int IN_W  = 3,
    parameter int OUT_W = (IN_W + 2) / 3
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [IN_W-1:0]  in_dat,
    output logic [OUT_W-1:0] and_q
);

    logic [3*OUT_W-1:0] pad;
    logic [OUT_W-1:0]   and_d;

    always_comb begin
        pad            = '1;
        pad[IN_W-1:0]  = in_dat;
        and_d          = and_q;
        if (EN) begin
            for (int g = 0; g < OUT_W; g++) begin
                and_d[g] = &pad[3*g +: 3];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            and_q <= '0;
        end else begin
            and_q <= and_d;
        end
    end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__nandn_pipe.sv
// Pipelined multi-channel WIDTH-input NAND; latency LEVELS advancing cycles, EN=0 stalls every stage.
// Optional saturating zero-output counter under GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN.
module gf180mcu_fd_sc_mcu7t5v0__nandn_pipe
    import gf180mcu_fd_sc_mcu7t5v0__nandn_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int CHANNELS = 1,
    parameter int CNT_W    = 16
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      EN,
    input  logic                      VALID_IN,
    input  logic [CHANNELS*WIDTH-1:0] A,
    output logic [CHANNELS-1:0]       ZN,
`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
    output logic [CNT_W-1:0]          ZERO_CNT,
`endif
    output logic                      VALID_OUT
);

    localparam int LEVELS = levels(WIDTH);
    localparam int TOT    = term_offset(WIDTH, LEVELS + 1);

    for (genvar c = 0; c < CHANNELS; c++) begin : ch_g
        // All tree levels of this channel, level 0 (raw inputs) in the low bits.
        logic [TOT-1:0] term;

        assign term[WIDTH-1:0] = A[c*WIDTH +: WIDTH];

        for (genvar k = 0; k < LEVELS; k++) begin : lvl_g
            localparam int IW    = level_terms(WIDTH, k);
            localparam int OW    = level_terms(WIDTH, k + 1);
            localparam int OFF_I = term_offset(WIDTH, k);
            localparam int OFF_O = term_offset(WIDTH, k + 1);

            gf180mcu_fd_sc_mcu7t5v0__nandn_level #(
                .IN_W  (IW),
                .OUT_W (OW)
            ) u_level (
                .CLK    (CLK),
                .RST    (RST),
                .EN     (EN),
                .in_dat (term[OFF_I +: IW]),
                .and_q  (term[OFF_O +: OW])
            );
        end

        assign ZN[c] = ~term[TOT-1];
    end

    logic [LEVELS-1:0] vld_q;
    logic [LEVELS-1:0] vld_d;

    always_comb begin
        vld_d = vld_q;
        if (EN) begin
            vld_d[0] = VALID_IN;
            for (int i = 1; i < LEVELS; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign VALID_OUT = vld_q[LEVELS-1];

`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Counts consumed output beats where some channel saw all-ones inputs; saturates.
    always_comb begin
        cnt_d = cnt_q;
        if (EN && VALID_OUT && !(&ZN) && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ZERO_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__nandn_pipe.sv
// Four DUT configurations share clock/reset/EN/VALID_IN; a queue-based model predicts every output.
module tb_gf180mcu_fd_sc_mcu7t5v0__nandn_pipe;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        EN = 1'b0;
    logic        VALID_IN = 1'b0;
    logic [2:0]  A3 = '0;
    logic [17:0] A9 = '0;
    logic [3:0]  A4 = '0;
    logic [0:0]  A1 = '0;
    logic [0:0]  ZN3, ZN4, ZN1;
    logic [1:0]  ZN9;
    logic        VO3, VO9, VO4, VO1;
`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
    logic [15:0] ZC3, ZC9, ZC4;
    logic [1:0]  ZC1;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    always #5 CLK = ~CLK;

    gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.WIDTH(3), .CHANNELS(1)) u_w3 (
        .CLK(CLK), .RST(RST), .EN(EN), .VALID_IN(VALID_IN), .A(A3), .ZN(ZN3),
`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
        .ZERO_CNT(ZC3),
`endif
        .VALID_OUT(VO3));

    gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.WIDTH(9), .CHANNELS(2)) u_w9 (
        .CLK(CLK), .RST(RST), .EN(EN), .VALID_IN(VALID_IN), .A(A9), .ZN(ZN9),
`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
        .ZERO_CNT(ZC9),
`endif
        .VALID_OUT(VO9));

    gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.WIDTH(4), .CHANNELS(1)) u_w4 (
        .CLK(CLK), .RST(RST), .EN(EN), .VALID_IN(VALID_IN), .A(A4), .ZN(ZN4),
`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
        .ZERO_CNT(ZC4),
`endif
        .VALID_OUT(VO4));

    gf180mcu_fd_sc_mcu7t5v0__nandn_pipe #(.WIDTH(1), .CHANNELS(1), .CNT_W(2)) u_w1 (
        .CLK(CLK), .RST(RST), .EN(EN), .VALID_IN(VALID_IN), .A(A1), .ZN(ZN1),
`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
        .ZERO_CNT(ZC1),
`endif
        .VALID_OUT(VO1));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int ws [4]  = '{3, 9, 4, 1};
    int chs[4]  = '{1, 2, 1, 1};
    int lvs[4]  = '{1, 2, 2, 1};
    int mz [4][$];
    bit mv [4][$];
    int mcnt = 0;

    function automatic logic [17:0] a_of(input int d);
        case (d)
            0:       return {15'b0, A3};
            1:       return A9;
            2:       return {14'b0, A4};
            default: return {17'b0, A1};
        endcase
    endfunction

    // Per channel: 1 unless every input bit is 1.
    function automatic int nand_of(input int d);
        logic [17:0] a;
        int res;
        bit all;
        a = a_of(d);
        res = 0;
        for (int c = 0; c < chs[d]; c++) begin
            all = 1'b1;
            for (int i = 0; i < ws[d]; i++) begin
                if (!a[c*ws[d] + i]) all = 1'b0;
            end
            if (!all) res = res | (1 << c);
        end
        return res;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            mcnt = 0;
        end else if (EN && mv[3].size() > 0 && mv[3][lvs[3]-1] &&
                     mz[3][lvs[3]-1] != ((1 << chs[3]) - 1) && mcnt < 3) begin
            mcnt = mcnt + 1;
        end
        for (int d = 0; d < 4; d++) begin
            if (RST) begin
                mz[d].delete();
                mv[d].delete();
                for (int i = 0; i < lvs[d]; i++) begin
                    mz[d].push_back((1 << chs[d]) - 1);
                    mv[d].push_back(1'b0);
                end
            end else if (EN) begin
                mz[d].push_front(nand_of(d));
                mv[d].push_front(VALID_IN);
                void'(mz[d].pop_back());
                void'(mv[d].pop_back());
            end
        end
    end

    function automatic logic [31:0] zn_act(input int d);
        case (d)
            0:       return {31'b0, ZN3};
            1:       return {30'b0, ZN9};
            2:       return {31'b0, ZN4};
            default: return {31'b0, ZN1};
        endcase
    endfunction

    function automatic logic vo_act(input int d);
        case (d)
            0:       return VO3;
            1:       return VO9;
            2:       return VO4;
            default: return VO1;
        endcase
    endfunction

    always @(negedge CLK) begin
        if (started) begin
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("model_zn_w%0d", ws[d]), zn_act(d), mz[d][lvs[d]-1]);
                chk($sformatf("model_vo_w%0d", ws[d]), {31'b0, vo_act(d)}, {31'b0, mv[d][lvs[d]-1]});
            end
`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
            chk("model_cnt_w1", {30'b0, ZC1}, mcnt);
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_in(input logic en, input logic vin, input logic [2:0] a3,
                          input logic [17:0] a9, input logic [3:0] a4, input logic a1);
        EN = en;
        VALID_IN = vin;
        A3 = a3;
        A9 = a9;
        A4 = a4;
        A1 = a1;
    endtask

`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
    int cnt_exp[6] = '{0, 1, 2, 3, 3, 3};
`endif

    initial begin
        cyc();
        cyc();
        started = 1'b1;
        chk("rst_zn3", {31'b0, ZN3}, 1);
        chk("rst_vo3", {31'b0, VO3}, 0);
        chk("rst_zn9", {30'b0, ZN9}, 3);
        chk("rst_vo9", {31'b0, VO9}, 0);

        RST = 1'b0;
        set_in(1, 1, 3'b111, {9'h1FF, 9'h1FE}, 4'hF, 1);
        cyc();
        chk("w3_allones_zn", {31'b0, ZN3}, 0);
        chk("w3_allones_vo", {31'b0, VO3}, 1);
        chk("w9_early_vo", {31'b0, VO9}, 0);
        chk("w9_early_zn", {30'b0, ZN9}, 3);

        set_in(1, 1, 3'b110, 18'h0, 4'h7, 1);
        cyc();
        chk("w3_110_zn", {31'b0, ZN3}, 1);
        chk("w9_mixed_zn", {30'b0, ZN9}, 2'b01);
        chk("w9_mixed_vo", {31'b0, VO9}, 1);
        chk("w4_pad_f_zn", {31'b0, ZN4}, 0);
        chk("w4_pad_f_vo", {31'b0, VO4}, 1);

        set_in(1, 0, 3'b000, 18'h0, 4'h7, 0);
        cyc();
        chk("w4_pad_7_zn", {31'b0, ZN4}, 1);
        chk("w9_zero_zn", {30'b0, ZN9}, 3);
        chk("w3_invalid_vo", {31'b0, VO3}, 0);

        // stall with a beat sitting in the first level
        set_in(1, 1, 3'b111, {9'h1FF, 9'h1FF}, 4'hF, 1);
        cyc();
        set_in(0, 0, 3'b000, 18'h0, 4'h0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stall_vo4", {31'b0, VO4}, 0);
            chk("stall_zn4", {31'b0, ZN4}, 1);
        end
        set_in(1, 0, 3'b000, 18'h0, 4'h0, 0);
        cyc();
        chk("stall_out_zn4", {31'b0, ZN4}, 0);
        chk("stall_out_vo4", {31'b0, VO4}, 1);
        chk("stall_out_zn9", {30'b0, ZN9}, 0);
        chk("stall_out_vo9", {31'b0, VO9}, 1);
        cyc();
        chk("stall_after_vo4", {31'b0, VO4}, 0);

        // reset one cycle after a beat enters the wide pipe
        set_in(1, 1, 3'b000, {9'h1FF, 9'h1FF}, 4'h0, 0);
        cyc();
        RST = 1'b1;
        set_in(1, 0, 3'b000, 18'h0, 4'h0, 0);
        cyc();
        chk("rmid_zn9", {30'b0, ZN9}, 3);
        chk("rmid_vo9", {31'b0, VO9}, 0);
        RST = 1'b0;
        cyc();
        chk("rmid_flush1_vo9", {31'b0, VO9}, 0);
        cyc();
        chk("rmid_flush2_vo9", {31'b0, VO9}, 0);
        chk("rmid_flush2_zn9", {30'b0, ZN9}, 3);

`ifdef GF180MCU_FD_SC_MCU7T5V0__NANDN_PIPE_ZERO_CNT_EN
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("cnt_rst", {30'b0, ZC1}, 0);
        for (int i = 0; i < 6; i++) begin
            set_in(1, (i < 5), 3'b000, 18'h0, 4'h0, (i < 5));
            cyc();
            chk($sformatf("cnt_beat%0d", i), {30'b0, ZC1}, cnt_exp[i]);
        end
        RST = 1'b1;
        cyc();
        RST = 1'b0;
        chk("cnt_rst_again", {30'b0, ZC1}, 0);
        set_in(1, 1, 3'b000, 18'h0, 4'h0, 0);
        cyc();
        set_in(1, 0, 3'b000, 18'h0, 4'h0, 0);
        cyc();
        chk("cnt_a0_noinc", {30'b0, ZC1}, 0);
        set_in(1, 1, 3'b000, 18'h0, 4'h0, 1);
        cyc();
        set_in(0, 0, 3'b000, 18'h0, 4'h0, 0);
        cyc();
        chk("cnt_stall_noinc", {30'b0, ZC1}, 0);
        set_in(1, 0, 3'b000, 18'h0, 4'h0, 0);
        cyc();
        chk("cnt_resume_inc", {30'b0, ZC1}, 1);
`endif

        set_in(1, 0, 3'b000, 18'h0, 4'h0, 0);
        cyc();
        cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
